// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring shift-and-subtract on operand magnitudes,
// one quotient bit per clock, with the signs applied in a final cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             dz_pend_q, dz_pend_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Magnitudes are unsigned, so the most negative operand still fits.
  assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign shifted = {r_q, a_q[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - b_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sq_d      = sq_q;
    sr_d      = sr_q;
    dbz_d     = dbz_q;
    dz_pend_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero divisor finishes one edge after capture; a_q still holds |dividend|.
        if (dz_pend_q) begin
          quot_d = '1;
          rem_d  = sr_q ? -a_q : a_q;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
        if (start) begin
          a_d   = dvd_abs;
          b_d   = dvs_abs;
          sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d  = dividend[WIDTH-1];
          cnt_d = CW'(WIDTH);
          r_d   = '0;
          if (!dz_pend_q) dbz_d = 1'b0;
          if (divisor == '0) dz_pend_d = 1'b1;
          else               state_d   = CALC;
        end
      end
      CALC: begin
        if (shifted >= {1'b0, b_q}) begin
          r_d = diff;
          a_d = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted[WIDTH-1:0];
          a_d = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        quot_d  = sq_q ? -a_q : a_q;
        rem_d   = sr_q ? -r_q : r_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sq_q      <= sq_d;
      sr_q      <= sr_d;
      dz_pend_q <= dz_pend_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients/remainders, latency,
// busy length, zero divisor, overflow, ignored start, back-to-back and mid-run reset.
module tb_seq_divider;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busyCnt;
  int doneSeen;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Assumes start is already high ahead of the accepting edge; counts edges to done.
  // injectAt >= 0 pulses a 9/3 start at that cycle to prove busy ignores it.
  task automatic waitDone(input int injectAt, output int latency, output int busyCycles);
    @(posedge clk); #1;
    start = 1'b0;
    latency = 0;
    busyCycles = busy ? 1 : 0;
    while (!done && latency < 100) begin
      if (latency == injectAt) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      latency++;
      if (busy) busyCycles++;
    end
    if (!done) checkOutput("done_timeout", 32'(latency), 32'd0);
    checkOutput("busy_with_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input int injectAt);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    waitDone(injectAt, lat, busyCnt);
  endtask

  initial begin
    logic [31:0] sDvd [3] = '{-32'sd100, 32'd100, -32'sd100};
    logic [31:0] sDvs [3] = '{32'd7, -32'sd7, -32'sd7};
    logic [31:0] sQ   [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] sR   [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_quot", quotient, 32'd0);
    checkOutput("rst_rem", remainder, 32'd0);
    checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(32'd100, 32'd7, -1);
    checkOutput("p7_latency", 32'(lat), 32'd33);
    checkOutput("p7_busy_cycles", 32'(busyCnt), 32'd33);
    checkOutput("p7_quot", quotient, 32'd14);
    checkOutput("p7_rem", remainder, 32'd2);
    checkOutput("p7_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    checkOutput("p7_done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("p7_quot_hold", quotient, 32'd14);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(sDvd[i], sDvs[i], -1);
      checkOutput($sformatf("sign%0d_quot", i), quotient, sQ[i]);
      checkOutput($sformatf("sign%0d_rem", i), remainder, sR[i]);
    end

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, -1);
    checkOutput("min_m1_quot", quotient, 32'h8000_0000);
    checkOutput("min_m1_rem", remainder, 32'd0);
    checkOutput("min_m1_dbz", {31'd0, div_by_zero}, 32'd0);

    applyStimulus(32'h8000_0000, 32'd3, -1);
    checkOutput("min_3_quot", quotient, 32'hD555_5556);
    checkOutput("min_3_rem", remainder, 32'hFFFF_FFFE);

    applyStimulus(32'd100, 32'd0, -1);
    checkOutput("dz_latency", 32'(lat), 32'd1);
    checkOutput("dz_busy_cycles", 32'(busyCnt), 32'd0);
    checkOutput("dz_quot", quotient, 32'hFFFF_FFFF);
    checkOutput("dz_rem", remainder, 32'd100);
    checkOutput("dz_flag", {31'd0, div_by_zero}, 32'd1);

    applyStimulus(32'd50, 32'd5, 10);
    checkOutput("ign_latency", 32'(lat), 32'd33);
    checkOutput("ign_quot", quotient, 32'd10);
    checkOutput("ign_rem", remainder, 32'd0);
    checkOutput("ign_dbz", {31'd0, div_by_zero}, 32'd0);

    // Launch straight from the done cycle.
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    waitDone(-1, lat, busyCnt);
    checkOutput("b2b_latency", 32'(lat), 32'd33);
    checkOutput("b2b_quot", quotient, 32'd3);
    checkOutput("b2b_rem", remainder, 32'd0);

    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quot", quotient, 32'd0);
    checkOutput("abort_rem", remainder, 32'd0);
    checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

    applyStimulus(32'd20, 32'd6, -1);
    checkOutput("post_latency", 32'(lat), 32'd33);
    checkOutput("post_quot", quotient, 32'd3);
    checkOutput("post_rem", remainder, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
